// File: rtl/hwpe_stream_source_credit_pkg.sv
// Shared types for the credit-based TCDM source streamer.
package hwpe_stream_source_credit_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_source_credit_t;

  typedef struct packed {
    logic             start;
    logic [31:0]      base;
    logic [CNT_W-1:0] trans_size;
    logic [CNT_W-1:0] line_len;
    logic [31:0]      line_stride;
  } ctrl_source_credit_t;

  typedef struct packed {
    logic ready_start;
    logic busy;
    logic done;
  } flags_source_credit_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/hwpe_stream_source_credit_lane.sv
// One TCDM lane: response FIFO, per-beat grant fence, credit and flush tracking.
module hwpe_stream_source_credit_lane #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        beat_go_i,
  input  logic        beat_done_i,
  output logic        credit_o,
  output logic        fenced_o,
  output logic        granted_o,
  output logic        flush_o,
  output logic        req_o,
  input  logic        gnt_i,
  input  logic [31:0] r_data_i,
  input  logic        r_valid_i,
  input  logic        pop_i,
  output logic        valid_o,
  output logic [31:0] data_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1) + 1;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] cnt_q;
  logic             granted_q, inflight_q, flush_q;
  logic             gnt_now, push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign req_o     = beat_go_i & ~granted_q;
  assign gnt_now   = req_o & gnt_i;
  assign fenced_o  = granted_q;
  assign granted_o = granted_q | gnt_now;
  assign credit_o  = (cnt_q + OCC_W'(inflight_q)) < OCC_W'(FIFO_DEPTH);
  assign flush_o   = flush_q;
  // a response owed to a cleared transfer must never reach the FIFO
  assign push      = r_valid_i & ~flush_q & ~clear_i;
  assign valid_o   = (cnt_q != '0);
  assign data_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      granted_q  <= 1'b0;
      inflight_q <= 1'b0;
      flush_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      granted_q  <= 1'b0;
      inflight_q <= 1'b0;
      flush_q    <= gnt_now;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      granted_q  <= granted_o & ~beat_done_i;
      inflight_q <= gnt_now;
      if (r_valid_i) flush_q <= 1'b0;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop_i})
        2'b10:   cnt_q <= cnt_q + OCC_W'(1);
        2'b01:   cnt_q <= cnt_q - OCC_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= r_data_i;
  end

  assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
    (push && !pop_i) |-> (cnt_q < OCC_W'(FIFO_DEPTH)));

endmodule

// File: rtl/hwpe_stream_source_credit.sv
// TCDM load streamer: 1-D/2-D strided reads over N lanes, credit-gated issue, emitted as one wide stream.
module hwpe_stream_source_credit
  import hwpe_stream_source_credit_pkg::*;
#(
  parameter int unsigned NB_TCDM_PORTS = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [31:0]                base_addr_i,
  input  logic [CNT_WIDTH-1:0]       trans_size_i,
  input  logic [CNT_WIDTH-1:0]       line_len_i,
  input  logic [31:0]                line_stride_i,
  output logic                       ready_start_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NB_TCDM_PORTS-1:0]   tcdm_req_o,
  input  logic [NB_TCDM_PORTS-1:0]   tcdm_gnt_i,
  output logic [NB_TCDM_PORTS*32-1:0] tcdm_add_o,
  output logic [NB_TCDM_PORTS-1:0]   tcdm_wen_o,
  output logic [NB_TCDM_PORTS*4-1:0] tcdm_be_o,
  output logic [NB_TCDM_PORTS*32-1:0] tcdm_data_o,
  input  logic [NB_TCDM_PORTS*32-1:0] tcdm_r_data_i,
  input  logic [NB_TCDM_PORTS-1:0]   tcdm_r_valid_i,
  output logic                       stream_valid_o,
  input  logic                       stream_ready_i,
  output logic [NB_TCDM_PORTS*32-1:0] stream_data_o,
  output logic [NB_TCDM_PORTS*4-1:0] stream_strb_o
);
  localparam int unsigned N          = NB_TCDM_PORTS;
  localparam logic [31:0] BEAT_BYTES = 32'(4 * N);

  state_source_credit_t state_q, state_d;
  ctrl_source_credit_t  ctrl;
  flags_source_credit_t flags;

  logic [CNT_WIDTH-1:0] issue_left_q, pop_left_q, word_left_q, line_len_q;
  logic [31:0]          beat_addr_q, line_addr_q, stride_q;
  logic                 done_q, done_d;
  logic [N-1:0]         lane_credit, lane_fenced, lane_granted, lane_flush, lane_valid;
  logic                 start_ok, launch, beat_go, beat_done, pop, line_wrap;

  assign ctrl = '{start:       start_i,
                  base:        word_align(base_addr_i),
                  trans_size:  CNT_W'(trans_size_i),
                  line_len:    CNT_W'(line_len_i),
                  line_stride: line_stride_i};

  assign start_ok  = (state_q == IDLE) & ~(|lane_flush);
  assign launch    = ctrl.start & start_ok;
  // once any lane holds a grant the beat is committed; credit only gates opening a new one
  assign beat_go   = (state_q == ISSUE) & ((|lane_fenced) | (&lane_credit));
  assign beat_done = (state_q == ISSUE) & (&lane_granted);
  assign pop       = (&lane_valid) & stream_ready_i;
  assign line_wrap = (line_len_q != '0) && (word_left_q == CNT_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          if (ctrl.trans_size == '0) done_d = 1'b1;
          else                       state_d = ISSUE;
        end
      end
      ISSUE: if (beat_done && issue_left_q == CNT_WIDTH'(1)) state_d = DRAIN;
      DRAIN: begin
        if (pop && pop_left_q == CNT_WIDTH'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      issue_left_q <= '0;
      pop_left_q   <= '0;
      word_left_q  <= '0;
      line_len_q   <= '0;
      stride_q     <= '0;
      beat_addr_q  <= '0;
      line_addr_q  <= '0;
    end else if (state_q == IDLE && launch) begin
      issue_left_q <= CNT_WIDTH'(ctrl.trans_size);
      pop_left_q   <= CNT_WIDTH'(ctrl.trans_size);
      word_left_q  <= CNT_WIDTH'(ctrl.line_len);
      line_len_q   <= CNT_WIDTH'(ctrl.line_len);
      stride_q     <= ctrl.line_stride;
      beat_addr_q  <= ctrl.base;
      line_addr_q  <= ctrl.base;
    end else begin
      if (beat_done) begin
        issue_left_q <= issue_left_q - CNT_WIDTH'(1);
        if (line_wrap) begin
          word_left_q <= line_len_q;
          line_addr_q <= line_addr_q + stride_q;
          beat_addr_q <= line_addr_q + stride_q;
        end else begin
          if (line_len_q != '0) word_left_q <= word_left_q - CNT_WIDTH'(1);
          beat_addr_q <= beat_addr_q + BEAT_BYTES;
        end
      end
      if (pop) pop_left_q <= pop_left_q - CNT_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    hwpe_stream_source_credit_lane #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) i_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .beat_go_i  (beat_go),
      .beat_done_i(beat_done),
      .credit_o   (lane_credit[i]),
      .fenced_o   (lane_fenced[i]),
      .granted_o  (lane_granted[i]),
      .flush_o    (lane_flush[i]),
      .req_o      (tcdm_req_o[i]),
      .gnt_i      (tcdm_gnt_i[i]),
      .r_data_i   (tcdm_r_data_i[32*i +: 32]),
      .r_valid_i  (tcdm_r_valid_i[i]),
      .pop_i      (pop),
      .valid_o    (lane_valid[i]),
      .data_o     (stream_data_o[32*i +: 32])
    );
    assign tcdm_add_o[32*i +: 32] = beat_addr_q + 32'(4 * i);
  end

  assign flags = '{ready_start: start_ok,
                   busy:        (state_q == ISSUE) || (state_q == DRAIN),
                   done:        done_q};

  assign ready_start_o  = flags.ready_start;
  assign busy_o         = flags.busy;
  assign done_o         = flags.done;
  assign tcdm_wen_o     = '1;
  assign tcdm_be_o      = '0;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = &lane_valid;
  assign stream_strb_o  = '1;

endmodule
